// File: rtl/mac_bias_accum_if.sv
// Handshake/data bundle between the MAC source and the ReLU-facing MAC stage.
interface mac_bias_accum_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = 10
);
  logic                  start;
  logic [CNT_W-1:0]      num_terms;
  logic [DATA_WIDTH-1:0] bias;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] act_in;
  logic [DATA_WIDTH-1:0] wgt_in;
  logic                  in_ready;
  logic                  busy;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid;
  logic                  sat;

  modport master (
    output start, num_terms, bias, in_valid, act_in, wgt_in,
    input  in_ready, busy, data_out, valid, sat
  );

  modport slave (
    input  start, num_terms, bias, in_valid, act_in, wgt_in,
    output in_ready, busy, data_out, valid, sat
  );
endinterface

// File: rtl/mac_bias_accum.sv
// Per-pixel signed Q16.16 multiply-accumulate with bias add, round-half-up
// and saturation back to Q16.16. One valid pulse per result.
module mac_bias_accum #(
  parameter int INT_BITS   = 16,
  parameter int FRAC_BITS  = 16,
  parameter int DATA_WIDTH = INT_BITS + FRAC_BITS,
  parameter int CNT_W      = 10,
  parameter int ACC_W      = 2*DATA_WIDTH + CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  mac_bias_accum_if.slave    io
);

  typedef enum logic [1:0] {IDLE, ACCUM, FINISH} state_t;

  localparam logic signed [ACC_W-1:0] HALF  =
    {{(ACC_W-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] MAX_R =
    {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_R =
    {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  state_t                    state, state_next;
  logic signed [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]          cnt;
  logic [CNT_W-1:0]          n_lat;
  logic [DATA_WIDTH-1:0]     bias_lat;
  logic [DATA_WIDTH-1:0]     data_q;
  logic                      valid_q;
  logic                      sat_q;

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   bias_ext;
  logic signed [ACC_W-1:0]   sum;
  logic signed [ACC_W-1:0]   rounded;
  logic signed [ACC_W-1:0]   r;
  logic [DATA_WIDTH-1:0]     clip_val;
  logic                      clip_flag;
  logic                      last_beat;

  // Product, bias alignment, rounding and clipping of the finished sum
  always_comb begin
    prod      = $signed(io.act_in) * $signed(io.wgt_in);
    prod_ext  = {{CNT_W{prod[2*DATA_WIDTH-1]}}, prod};
    bias_ext  = {{(ACC_W-DATA_WIDTH-FRAC_BITS){bias_lat[DATA_WIDTH-1]}},
                 bias_lat, {FRAC_BITS{1'b0}}};
    sum       = acc + bias_ext;
    rounded   = sum + HALF;
    r         = rounded >>> FRAC_BITS;
    clip_flag = 1'b0;
    clip_val  = r[DATA_WIDTH-1:0];
    if (r > MAX_R) begin
      clip_val  = MAX_R[DATA_WIDTH-1:0];
      clip_flag = 1'b1;
    end else if (r < MIN_R) begin
      clip_val  = MIN_R[DATA_WIDTH-1:0];
      clip_flag = 1'b1;
    end
    last_beat = (cnt == n_lat - CNT_W'(1));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (io.start) state_next = (io.num_terms == '0) ? FINISH : ACCUM;
      ACCUM:  if (io.in_valid && last_beat) state_next = FINISH;
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Accumulator, term counter, latched parameters and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      cnt      <= '0;
      n_lat    <= '0;
      bias_lat <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (io.start) begin
            n_lat    <= io.num_terms;
            bias_lat <= io.bias;
            acc      <= '0;
            cnt      <= '0;
          end
        end
        ACCUM: begin
          if (io.in_valid) begin
            acc <= acc + prod_ext;
            cnt <= cnt + CNT_W'(1);
          end
        end
        FINISH: begin
          data_q  <= clip_val;
          valid_q <= 1'b1;
          sat_q   <= clip_flag;
        end
        default: ;
      endcase
    end
  end

  assign io.in_ready = (state == ACCUM);
  assign io.busy     = (state == ACCUM) || (state == FINISH);
  assign io.data_out = data_q;
  assign io.valid    = valid_q;
  assign io.sat      = sat_q;

endmodule

// File: doc/mac_bias_accum.md
# mac_bias_accum

Per-output-pixel multiply-accumulate stage feeding the ReLU stage of the MobileNetV3 convolution datapath. It accepts a stream of signed Q16.16 activation/weight pairs, accumulates their full-precision products over a programmable number of terms, then adds a Q16.16 bias, rounds and saturates back to Q16.16. Each result is presented with a one-cycle `valid` pulse that drives the ReLU stage's `data_in`/`enable` directly.

## Interface
- `INT_BITS`, 16, integer bits of the signed fixed-point format
- `FRAC_BITS`, 16, fractional bits of the signed fixed-point format
- `DATA_WIDTH`, `INT_BITS+FRAC_BITS`, operand/result width
- `CNT_W`, 10, term-counter width; up to 2^CNT_W−1 terms per result
- `ACC_W`, `2*DATA_WIDTH+CNT_W`, accumulator width; guarantees no accumulator wrap
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: begin a new result; sampled only in IDLE.
- `num_terms` in CNT_W: number of product terms; latched on accepted `start`.
- `bias` in DATA_WIDTH: signed Q16.16 bias; latched on accepted `start`.
- `in_valid` in 1: an act/wgt pair is present.
- `act_in` in DATA_WIDTH: signed Q16.16 activation.
- `wgt_in` in DATA_WIDTH: signed Q16.16 weight.
- `in_ready` out 1: high in ACCUM; a beat transfers when `in_valid & in_ready`.
- `busy` out 1: high in ACCUM and FINISH.
- `data_out` out DATA_WIDTH: signed Q16.16 result; holds until the next result.
- `valid` out 1: one-cycle pulse when `data_out` is updated.
- `sat` out 1: pulses with `valid` when the result was clipped.

## Operation
- States: IDLE, ACCUM, FINISH.
- **IDLE**
  - `start=1`, `num_terms>=1`: latch `num_terms` and `bias`, clear the accumulator and counter, go to ACCUM.
  - `start=1`, `num_terms==0`: latch `bias`, clear the accumulator, go directly to FINISH.
- **ACCUM**
  - On each accepted beat: `acc += sign_ext(act_in*wgt_in)`, using a signed 2·DATA_WIDTH product in Q32.32, sign-extended to ACC_W; then `cnt++`.
  - The accepted beat with `cnt == num_terms-1` moves the block to FINISH.
  - Cycles with `in_valid=0` change nothing.
- **FINISH** (exactly one cycle):
  - `sum = acc + (sign_ext(bias) << FRAC_BITS)`
  - `r = (sum + 2^(FRAC_BITS-1)) >>> FRAC_BITS`, i.e. round half toward +∞.
  - Clip `r` to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
  - Register the clipped value into `data_out`; set `valid<=1` and `sat<=clipped`; go to IDLE.
- `start` outside IDLE is ignored; it has no effect and is not queued.
- `in_valid` outside ACCUM is ignored; `in_ready=0` there, so no beat transfers.
- `valid` and `sat` are single-cycle; `data_out` is not cleared after the pulse.
- Reset (any state): state=IDLE, acc=0, cnt=0, `data_out=0`, `valid=0`, `sat=0`, `in_ready=0`, `busy=0`. A reset during ACCUM or FINISH aborts the result, and no `valid` is produced for it.

## Timing
- Cycle 0: `start` is accepted (IDLE).
- Cycles 1..K: ACCUM with `in_ready=1`, when `in_valid` is held high.
- Cycle K+1: FINISH.
- Cycle K+2: `valid=1` with the new `data_out`.
- Latency from `start` to `valid` is K+2 cycles plus any `in_valid` gap cycles.
- With `num_terms=0`: FINISH in cycle 1, `valid` in cycle 2.
- The `valid` cycle is an IDLE cycle, so a `start` there is accepted.
- Back-to-back throughput: one result per K+2 cycles.
- `in_ready` and `busy` are registered state decodes and have no combinational path from inputs.

## Test plan
- **Basic accumulate.** K=3; act = 0x00010000, 0x00020000, 0x00030000; wgt = 0x00008000 each; bias = 0x00004000; `in_valid` continuous -> `data_out=0x00034000` (3.25) with `valid` in cycle 5, `sat=0`.
- **Saturation.**
  - K=2, act=0x7FFF0000, wgt=0x00020000 -> `data_out=0x7FFFFFFF`, `sat=1`.
  - K=2, act=0x80000000, wgt=0x00020000 -> `data_out=0x80000000`, `sat=1`.
- **Rounding.** K=1, bias=0, wgt=0x00008000:
  - act=0x00000001 -> `0x00000001`.
  - act=0xFFFFFFFF -> `0x00000000`.
  - act=0x00000003 -> `0x00000002`.
- **Gaps and zero terms.**
  - K=4 with `in_valid` toggled 1,0,1,0,… -> exactly 4 beats counted; `valid` arrives 3 cycles later than the no-gap case; sum is correct.
  - `num_terms=0`, bias=0xFFFF0000 -> `data_out=0xFFFF0000` in cycle 2.
- **Ignored start and mid-run reset.**
  - `start` pulsed during ACCUM -> ignored; the result matches a single run.
  - `rst_n` low in the second ACCUM cycle -> no `valid`, all outputs 0; a fresh `start` then produces a correct result.
- **Back-to-back.** `start` for result B asserted in result A's `valid` cycle -> B is accepted; results A and B are both correct and their `valid` pulses are K+2 cycles apart.
